// File: rtl/instr_decode_stage.sv
// RV32 decode stage: decodes fields, format and immediate, then queues the record in a small skid FIFO.
// Define DECODE_ILLEGAL_EN to add the registered illegal-instruction output.
module instr_decode_stage #(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(BUF_DEPTH);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_X = 3'd7;

`ifdef DECODE_ILLEGAL_EN
    localparam int REC_W = XLEN + 36;
`else
    localparam int REC_W = XLEN + 35;
`endif

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;
    logic             push;
    logic             pop;

    logic [2:0]       fmt_dec;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  imm_dec;
    logic [REC_W-1:0] rec_next;
    logic [REC_W-1:0] head_rec;
    logic [REC_W-1:0] entry_rd [BUF_DEPTH];

    assign in_ready  = (count_reg < DEPTH_C) && !rst;
    assign out_valid = (count_reg != '0);
    // A flushed cycle never writes, so the dropped word cannot reappear.
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_comb begin
        fmt_dec = FMT_X;
        imm32   = '0;
        case (instruction[6:0])
            7'b0110011:                                     fmt_dec = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt_dec = FMT_I;
            7'b0100011:                                     fmt_dec = FMT_S;
            7'b1100011:                                     fmt_dec = FMT_B;
            7'b0110111, 7'b0010111:                         fmt_dec = FMT_U;
            7'b1101111:                                     fmt_dec = FMT_J;
            default:                                        fmt_dec = FMT_X;
        endcase
        case (fmt_dec)
            FMT_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
            FMT_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            FMT_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
            FMT_U: imm32 = {instruction[31:12], 12'b0};
            FMT_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed cast widens to XLEN by replicating bit 31.
    assign imm_dec = XLEN'($signed(imm32));

`ifdef DECODE_ILLEGAL_EN
    logic ill_dec;
    assign ill_dec = (fmt_dec == FMT_X) || (instruction[1:0] != 2'b11) ||
                     ((fmt_dec == FMT_R) && (instruction[31:25] != 7'b0000000) &&
                      (instruction[31:25] != 7'b0100000));
    assign rec_next = {ill_dec, imm_dec, fmt_dec, instruction};
`else
    assign rec_next = {imm_dec, fmt_dec, instruction};
`endif

    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
        logic [REC_W-1:0] rec_reg;
        always_ff @(posedge clk) begin
            if (push && (tail_reg == PTR_W'(gi))) begin
                rec_reg <= rec_next;
            end
        end
        assign entry_rd[gi] = rec_reg;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Empty buffer presents an all-zero record so reset leaves every output at 0.
    assign head_rec = out_valid ? entry_rd[head_reg] : '0;

    assign opcode = head_rec[6:0];
    assign rd     = head_rec[11:7];
    assign funct3 = head_rec[14:12];
    assign rs1    = head_rec[19:15];
    assign rs2    = head_rec[24:20];
    assign funct7 = head_rec[31:25];
    assign fmt    = head_rec[34:32];
    assign imm    = head_rec[XLEN+34:35];
`ifdef DECODE_ILLEGAL_EN
    assign illegal = head_rec[XLEN+35];
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: a queue model checks every cycle, literal checks pin the model.
module tb_instr_decode_stage;

    localparam int XLEN      = 32;
    localparam int BUF_DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [31:0]     instruction = '0;
    logic            in_ready;
    logic            out_valid;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
`ifdef DECODE_ILLEGAL_EN
    logic            illegal;
`endif

    instr_decode_stage #(.XLEN(XLEN), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .fmt(fmt)
`ifdef DECODE_ILLEGAL_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     word;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
        int              cyc;
    } rec_t;

    rec_t mq[$];
    rec_t popped[$];
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint sx(input longint val, input int bits);
        if (val >= (longint'(1) << (bits - 1))) return val - (longint'(1) << bits);
        return val;
    endfunction

    function automatic rec_t model_decode(input logic [31:0] w);
        rec_t   e;
        longint v;
        int     f;
        case (w[6:0])
            7'h33:                      f = 0;
            7'h13, 7'h03, 7'h67, 7'h73: f = 1;
            7'h23:                      f = 2;
            7'h63:                      f = 3;
            7'h37, 7'h17:               f = 4;
            7'h6F:                      f = 5;
            default:                    f = 7;
        endcase
        case (f)
            1: v = sx(longint'(w[31:20]), 12);
            2: v = sx(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
            3: v = sx(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 +
                      longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
            4: v = sx(longint'(w[31:12]) * 4096, 32);
            5: v = sx(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 +
                      longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
            default: v = 0;
        endcase
        e.word = w;
        e.fmt  = f[2:0];
        e.imm  = v[XLEN-1:0];
        e.ill  = (f == 7) || (w[1:0] != 2'b11) ||
                 ((f == 0) && (w[31:25] != 7'h00) && (w[31:25] != 7'h20));
        e.cyc  = 0;
        return e;
    endfunction

    // Model: FIFO of decoded records updated from the sampled handshakes.
    always @(posedge clk) begin
        bit do_push;
        bit do_pop;
        cyc++;
        do_push = in_valid && (mq.size() < BUF_DEPTH);
        do_pop  = (mq.size() != 0) && out_ready;
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (do_pop)  mq.delete(0);
            if (do_push) mq.push_back(model_decode(instruction));
        end
    end

    always @(negedge clk) begin
        rec_t r;
        check("in_ready", in_ready, (!rst && (mq.size() < BUF_DEPTH)));
        check("out_valid", out_valid, (mq.size() != 0));
        if (mq.size() != 0) begin
            check("head_word", {funct7, rs2, rs1, funct3, rd, opcode}, mq[0].word);
            check("head_imm", imm, mq[0].imm);
            check("head_fmt", fmt, mq[0].fmt);
`ifdef DECODE_ILLEGAL_EN
            check("head_illegal", illegal, mq[0].ill);
`endif
        end
        if (!rst && out_valid && out_ready) begin
            r.word = {funct7, rs2, rs1, funct3, rd, opcode};
            r.imm  = imm;
            r.fmt  = fmt;
`ifdef DECODE_ILLEGAL_EN
            r.ill  = illegal;
`else
            r.ill  = 1'b0;
`endif
            r.cyc  = cyc;
            popped.push_back(r);
        end
    end

    task automatic send(input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        instruction = w;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        if (!ok) check("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] stream_w [10] = '{32'h8000006F, 32'h00012083, 32'h00000517, 32'hFFF00067,
                                   32'h00000073, 32'h0000007F, 32'h800000B7, 32'h40208133,
                                   32'h80000E63, 32'hFE112E23};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_imm", imm, '0);
        check("rst_fmt", fmt, 3'd0);
        check("rst_opcode", opcode, 7'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: addi x1,x2,-1
        out_ready = 1'b1;
        send(32'hFFF10093);
        @(negedge clk);
        check("t1_out_valid", out_valid, 1'b1);
        check("t1_opcode", opcode, 7'h13);
        check("t1_rd", rd, 5'd1);
        check("t1_rs1", rs1, 5'd2);
        check("t1_funct3", funct3, 3'd0);
        check("t1_imm", imm, 32'hFFFFFFFF);
        check("t1_fmt", fmt, 3'd1);
        @(posedge clk);
        #1;
        idle(2);

        // 2: sw, beq, lui streamed with no stall
        popped.delete();
        send(32'h0051A423);
        send(32'hFE000EE3);
        send(32'h123452B7);
        idle(3);
        check("t2_count", popped.size(), 3);
        if (popped.size() >= 3) begin
            check("t2_sw_fmt", popped[0].fmt, 3'd2);
            check("t2_sw_rs1", popped[0].word[19:15], 5'd3);
            check("t2_sw_rs2", popped[0].word[24:20], 5'd5);
            check("t2_sw_imm", popped[0].imm, 32'h8);
            check("t2_beq_fmt", popped[1].fmt, 3'd3);
            check("t2_beq_imm", popped[1].imm, 32'hFFFFFFFC);
            check("t2_lui_fmt", popped[2].fmt, 3'd4);
            check("t2_lui_rd", popped[2].word[11:7], 5'd5);
            check("t2_lui_imm", popped[2].imm, 32'h12345000);
            check("t2_consecutive", popped[2].cyc - popped[0].cyc, 2);
        end

        // 3: stall fills buffer, third word waits for a pop
        popped.delete();
        out_ready = 1'b0;
        send(32'h00A00093);
        send(32'h00208133);
        in_valid = 1'b1;
        instruction = 32'h0000006F;
        @(negedge clk);
        check("t3_full_in_ready", in_ready, 1'b0);
        check("t3_head_a", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h00A00093);
        @(posedge clk);
        @(negedge clk);
        check("t3_head_stable", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h00A00093);
        check("t3_imm_stable", imm, 32'd10);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("t3_still_full", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("t3_ready_after_pop", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        idle(3);
        check("t3_count", popped.size(), 3);
        if (popped.size() >= 3) begin
            check("t3_order0", popped[0].word, 32'h00A00093);
            check("t3_order1", popped[1].word, 32'h00208133);
            check("t3_order2", popped[2].word, 32'h0000006F);
        end

        // 4: full buffer drained while streaming ten more words
        popped.delete();
        out_ready = 1'b0;
        send(32'h00100093);
        send(32'h00200113);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(stream_w[i]);
        idle(4);
        check("t4_count", popped.size(), 12);
        if (popped.size() >= 12) begin
            check("t4_order_f0", popped[0].word, 32'h00100093);
            check("t4_order_f1", popped[1].word, 32'h00200113);
            for (int i = 0; i < 10; i++) check("t4_order", popped[i+2].word, stream_w[i]);
            check("t4_jal_fmt", popped[2].fmt, 3'd5);
            check("t4_jal_imm", popped[2].imm, 32'hFFF00000);
            check("t4_unknown_fmt", popped[7].fmt, 3'd7);
            check("t4_unknown_imm", popped[7].imm, 32'h0);
            check("t4_no_bubble", popped[11].cyc - popped[0].cyc, 11);
        end

        // 5a: flush with two entries and a word offered
        popped.delete();
        out_ready = 1'b0;
        send(32'h00300193);
        send(32'h00400213);
        in_valid = 1'b1;
        instruction = 32'h00500293;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_flush_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        // 5b: flush with one entry while it is popped and a new word is pushed
        send(32'h00600313);
        out_ready = 1'b1;
        in_valid = 1'b1;
        instruction = 32'h00700393;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        idle(3);
        check("t5_flush_pops", popped.size(), 1);
        if (popped.size() >= 1) check("t5_flush_popped_word", popped[0].word, 32'h00600313);

        // 5c: reset mid-stream
        popped.delete();
        out_ready = 1'b0;
        send(32'h00800413);
        send(32'h00900493);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_out_valid", out_valid, 1'b0);
        check("t5_rst_in_ready", in_ready, 1'b0);
        check("t5_rst_opcode", opcode, 7'd0);
        check("t5_rst_rd", rd, 5'd0);
        check("t5_rst_imm", imm, '0);
        check("t5_rst_fmt", fmt, 3'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        idle(3);
        check("t5_rst_lost", popped.size(), 0);

`ifdef DECODE_ILLEGAL_EN
        // 6: illegal flag
        popped.delete();
        send(32'h00000000);
        send(32'hFE000033);
        send(32'h40000033);
        idle(3);
        check("t6_count", popped.size(), 3);
        if (popped.size() >= 3) begin
            check("t6_zero_illegal", popped[0].ill, 1'b1);
            check("t6_f7_illegal", popped[1].ill, 1'b1);
            check("t6_sub_illegal", popped[2].ill, 1'b0);
            check("t6_sub_fmt", popped[2].fmt, 3'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
